// File: rtl/leak_decoder_pkg.sv
// Shared constants, FSM state type and popcount helper for the AES-T100 leak decoder.
package leak_decoder_pkg;

    localparam int              LFSR_W      = 20;
    localparam logic [19:0]     LFSR_SEED   = 20'h00001;
    localparam int              LFSR_TAP_HI = 19;
    localparam int              LFSR_TAP_LO = 16;
    localparam int              LANES       = 8;
    localparam int              REPL        = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        DONE
    } state_e;

    function automatic logic [3:0] popcount8(input logic [REPL-1:0] v);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < REPL; k++) begin
            s = s + {3'b000, v[k]};
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_model.sv
// 20-bit Fibonacci LFSR (taps 19,16) with synchronous seed reload; mirrors the Trojan's counter.
module lfsr_model
    import leak_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              i_reload,
    output logic [LFSR_W-1:0] o_c
);

    logic [LFSR_W-1:0] r_c;

    always_ff @(posedge clk) begin
        if (i_reload) begin
            r_c <= LFSR_SEED;
        end else begin
            r_c <= {r_c[LFSR_W-2:0], r_c[LFSR_TAP_HI] ^ r_c[LFSR_TAP_LO]};
        end
    end

    assign o_c = r_c;

endmodule

// File: rtl/leak_decoder.sv
// Recovers key[7:0] from the AES-T100 load bus by unmasking, replica voting and windowed accumulation.
// Optional build macro LEAK_DECODER_ERRCNT_EN adds the replica-consistency error counter.
module leak_decoder
    import leak_decoder_pkg::*;
#(
    parameter int NUM_SAMPLES = 16,
    parameter int VOTE_THR    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lfsr_sync,
    input  logic        start,
    input  logic        load_valid,
    input  logic [63:0] load_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  key_byte,
    output logic [7:0]  tie,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int ACC_W = $clog2(NUM_SAMPLES) + 2;

    logic [LFSR_W-1:0]       w_c;
    logic [LFSR_W-1:0]       r_prev_c;
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [7:0]              r_n;
    logic                    w_take;
    logic                    w_last;
    logic                    w_clear;
    logic [3:0]              w_pc      [LANES];
    logic [LANES-1:0]        w_b;
    logic signed [ACC_W-1:0] r_acc     [LANES];
    logic signed [ACC_W-1:0] w_acc_nxt [LANES];
    logic [LANES-1:0]        w_key_nxt;
    logic [LANES-1:0]        w_tie_nxt;
    logic [7:0]              r_key;
    logic [7:0]              r_tie;
    logic                    w_unused;

    lfsr_model u_lfsr (
        .clk      (clk),
        .i_reload (rst | lfsr_sync),
        .o_c      (w_c)
    );

    // Trojan registers its leak one cycle late, so samples decode against last cycle's counter.
    always_ff @(posedge clk) begin
        r_prev_c <= w_c;
    end

    assign w_unused = ^r_prev_c[LFSR_W-1:LANES];

    assign w_take  = (r_state == ACQ) && load_valid;
    assign w_last  = w_take && (r_n == 8'(NUM_SAMPLES - 1));
    assign w_clear = (r_state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_nxt = ACQ;
            ACQ:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_pc[gi]      = popcount8(load_in[8*gi +: 8]);
        assign w_b[gi]       = (w_pc[gi] >= 4'(VOTE_THR)) ^ r_prev_c[gi];
        assign w_acc_nxt[gi] = w_b[gi] ? (r_acc[gi] + ACC_W'(1)) : (r_acc[gi] - ACC_W'(1));
        assign w_key_nxt[gi] = !w_acc_nxt[gi][ACC_W-1] && (w_acc_nxt[gi] != '0);
        assign w_tie_nxt[gi] = (w_acc_nxt[gi] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            r_n   <= '0;
            r_key <= '0;
            r_tie <= '0;
        end else if (w_clear) begin
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            r_n <= '0;
        end else if (w_take) begin
            for (int l = 0; l < LANES; l++) r_acc[l] <= w_acc_nxt[l];
            r_n <= r_n + 8'd1;
            if (w_last) begin
                r_key <= w_key_nxt;
                r_tie <= w_tie_nxt;
            end
        end
    end

`ifdef LEAK_DECODER_ERRCNT_EN
    logic [3:0] w_bad_cnt;
    logic [8:0] w_err_sum;
    logic [7:0] r_err;

    // A lane is inconsistent when its replicas disagree among themselves.
    always_comb begin
        w_bad_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((w_pc[l] != 4'd0) && (w_pc[l] != 4'd8)) w_bad_cnt = w_bad_cnt + 4'd1;
        end
    end

    assign w_err_sum = {1'b0, r_err} + {5'b00000, w_bad_cnt};

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_err <= '0;
        end else if (w_take) begin
            r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign err_cnt = r_err;
`else
    assign err_cnt = 8'h00;
`endif

    assign busy      = (r_state == ACQ);
    assign out_valid = (r_state == DONE);
    assign key_byte  = r_key;
    assign tie       = r_tie;

endmodule
